// File: rtl/irrigation_pkg.sv
// -----------------------------------------------------------------------------
// irrigation_pkg
// Shared definitions for the irrigation controller and its actuator sequencer.
//   - Mode codes driven by the controller state register (also used by the
//     controller itself).
//   - Sequencer state encoding used by irrigation_actuator.
//   - Small helper to classify modes that draw water from the tank.
// -----------------------------------------------------------------------------
package irrigation_pkg;

    localparam logic [1:0] MODE_IDLE      = 2'b00;
    localparam logic [1:0] MODE_SPRINKLER = 2'b01;
    localparam logic [1:0] MODE_FILLING   = 2'b10;
    localparam logic [1:0] MODE_DRIP      = 2'b11;

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_OPEN  = 3'd1,
        S_RUN   = 3'd2,
        S_STOP  = 3'd3,
        S_FAULT = 3'd4
    } seq_state_t;

    // Sprinkler and drip pump out of the tank, so they are the modes that
    // must be protected against running the pump dry.
    function automatic logic draws_from_tank(input logic [1:0] mode);
        return (mode == MODE_SPRINKLER) || (mode == MODE_DRIP);
    endfunction

endpackage

// File: rtl/irrigation_actuator_seq_counter.sv
// -----------------------------------------------------------------------------
// seq_counter
// Shared sequencing counter for the actuator FSM. Clears to zero, counts up
// while enabled and saturates at all-ones instead of wrapping. The terminal
// value is supplied by the caller so one counter serves every timed state.
//   clk      : system clock
//   rst      : synchronous active-high reset
//   clear    : force count to zero (wins over enable)
//   enable   : increment (held at all-ones once reached)
//   terminal : value to compare against
//   at_term  : count == terminal
// -----------------------------------------------------------------------------
module seq_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] terminal,
    output logic             at_term
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

    assign at_term = (count == terminal);

endmodule

// File: rtl/irrigation_actuator.sv
// -----------------------------------------------------------------------------
// irrigation_actuator
// Converts the controller mode code into safely sequenced actuator drives:
// the selected valve opens VALVE_DLY cycles before the pump starts, the pump
// stops PUMP_STOP_DLY cycles before the valve closes, and a mode switch always
// passes through a fully closed cycle. Dry-run (sprinkler/drip with the tank
// below minimum) and fill-watchdog (no level change while filling) protection
// latch a fault that only initialize clears.
//   clk              : system clock
//   initialize       : synchronous active-high reset
//   state[1:0]       : requested mode (00 idle, 01 sprinkler, 10 fill, 11 drip)
//   water_tank_level : thermometer code, bit0 minimum .. bit3 full
//   pump_on          : pump enable
//   valve_sprinkler  : sprinkler valve open
//   valve_drip       : drip valve open
//   valve_fill       : tank-fill valve open
//   active           : sequencer not in S_OFF
//   fault            : sticky fault indicator
// All outputs are decoded from registered state only.
// -----------------------------------------------------------------------------
module irrigation_actuator
    import irrigation_pkg::*;
#(
    parameter int VALVE_DLY     = 4,
    parameter int PUMP_STOP_DLY = 4,
    parameter int FILL_TIMEOUT  = 1000,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       initialize,
    input  logic [1:0] state,
    input  logic [3:0] water_tank_level,
    output logic       pump_on,
    output logic       valve_sprinkler,
    output logic       valve_drip,
    output logic       valve_fill,
    output logic       active,
    output logic       fault
);

    localparam logic [CNT_W-1:0] OPEN_TERM = CNT_W'(VALVE_DLY - 1);
    localparam logic [CNT_W-1:0] STOP_TERM = CNT_W'(PUMP_STOP_DLY - 1);
    localparam logic [CNT_W-1:0] FILL_TERM = CNT_W'(FILL_TIMEOUT - 1);

    seq_state_t       fsm_q, fsm_d;
    logic [1:0]       target_q, target_d;
    logic [3:0]       snapshot_q, snapshot_d;

    logic             cnt_clear;
    logic             cnt_enable;
    logic [CNT_W-1:0] cnt_term;
    logic             cnt_at_term;

    seq_counter #(
        .CNT_W (CNT_W)
    ) u_seq_counter (
        .clk      (clk),
        .rst      (initialize),
        .clear    (cnt_clear),
        .enable   (cnt_enable),
        .terminal (cnt_term),
        .at_term  (cnt_at_term)
    );

    always_ff @(posedge clk) begin
        if (initialize) begin
            fsm_q      <= S_OFF;
            target_q   <= MODE_IDLE;
            snapshot_q <= '0;
        end else begin
            fsm_q      <= fsm_d;
            target_q   <= target_d;
            snapshot_q <= snapshot_d;
        end
    end

    always_comb begin
        fsm_d      = fsm_q;
        target_d   = target_q;
        snapshot_d = snapshot_q;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;
        cnt_term   = '0;

        case (fsm_q)
            S_OFF: begin
                if (state != MODE_IDLE) begin
                    target_d  = state;
                    cnt_clear = 1'b1;
                    fsm_d     = S_OPEN;
                end
            end

            S_OPEN: begin
                cnt_term = OPEN_TERM;
                if (state != target_q) begin
                    // Request withdrawn or changed before the pump started:
                    // close via the normal stop path.
                    cnt_clear = 1'b1;
                    fsm_d     = S_STOP;
                end else if (cnt_at_term) begin
                    cnt_clear  = 1'b1;
                    snapshot_d = water_tank_level;
                    fsm_d      = S_RUN;
                end else begin
                    cnt_enable = 1'b1;
                end
            end

            S_RUN: begin
                cnt_term = FILL_TERM;
                if (draws_from_tank(target_q) && !water_tank_level[0]) begin
                    fsm_d = S_FAULT;
                end else if ((target_q == MODE_FILLING) &&
                             (water_tank_level == snapshot_q) && cnt_at_term) begin
                    fsm_d = S_FAULT;
                end else if (state != target_q) begin
                    cnt_clear = 1'b1;
                    fsm_d     = S_STOP;
                end else if (target_q == MODE_FILLING) begin
                    // Any level movement proves the fill is progressing and
                    // restarts the watchdog, even on the timeout cycle itself.
                    if (water_tank_level != snapshot_q) begin
                        snapshot_d = water_tank_level;
                        cnt_clear  = 1'b1;
                    end else begin
                        cnt_enable = 1'b1;
                    end
                end
            end

            S_STOP: begin
                // Runs to completion regardless of the requested mode so the
                // valve never closes on a pressurised line.
                cnt_term = STOP_TERM;
                if (cnt_at_term) begin
                    cnt_clear = 1'b1;
                    fsm_d     = S_OFF;
                end else begin
                    cnt_enable = 1'b1;
                end
            end

            S_FAULT: begin
                fsm_d = S_FAULT;
            end

            default: begin
                fsm_d = S_OFF;
            end
        endcase
    end

    // Output decode from registered state and target only.
    logic valve_en;

    always_comb begin
        valve_en        = (fsm_q == S_OPEN) || (fsm_q == S_RUN) || (fsm_q == S_STOP);
        pump_on         = (fsm_q == S_RUN);
        valve_sprinkler = valve_en && (target_q == MODE_SPRINKLER);
        valve_drip      = valve_en && (target_q == MODE_DRIP);
        valve_fill      = valve_en && (target_q == MODE_FILLING);
        active          = (fsm_q != S_OFF);
        fault           = (fsm_q == S_FAULT);
    end

endmodule

// File: tb/tb_irrigation_actuator.sv
// -----------------------------------------------------------------------------
// tb_irrigation_actuator
// Directed bench for irrigation_actuator with VALVE_DLY=4, PUMP_STOP_DLY=4,
// FILL_TIMEOUT=8. Outputs are compared as a packed vector
// {fault, active, pump_on, valve_sprinkler, valve_drip, valve_fill}.
// -----------------------------------------------------------------------------
module tb_irrigation_actuator;

    logic       clk = 1'b0;
    logic       initialize;
    logic [1:0] state;
    logic [3:0] water_tank_level;
    logic       pump_on, valve_sprinkler, valve_drip, valve_fill, active, fault;

    int errors = 0;
    int checks = 0;

    // Expected output vectors {fault,active,pump,spr,drip,fill}
    localparam logic [5:0] ALL_OFF   = 6'b000000;
    localparam logic [5:0] OPEN_SPR  = 6'b010100;
    localparam logic [5:0] RUN_SPR   = 6'b011100;
    localparam logic [5:0] OPEN_DRIP = 6'b010010;
    localparam logic [5:0] RUN_DRIP  = 6'b011010;
    localparam logic [5:0] OPEN_FILL = 6'b010001;
    localparam logic [5:0] RUN_FILL  = 6'b011001;
    localparam logic [5:0] FAULTED   = 6'b110000;

    irrigation_actuator #(
        .VALVE_DLY     (4),
        .PUMP_STOP_DLY (4),
        .FILL_TIMEOUT  (8),
        .CNT_W         (16)
    ) dut (
        .clk              (clk),
        .initialize       (initialize),
        .state            (state),
        .water_tank_level (water_tank_level),
        .pump_on          (pump_on),
        .valve_sprinkler  (valve_sprinkler),
        .valve_drip       (valve_drip),
        .valve_fill       (valve_fill),
        .active           (active),
        .fault            (fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [5:0] exp);
        logic [5:0] got;
        got = {fault, active, pump_on, valve_sprinkler, valve_drip, valve_fill};
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        initialize = 1'b1;
        state      = 2'b00;
        tick();
        initialize = 1'b0;
    endtask

    initial begin
        initialize       = 1'b1;
        state            = 2'b00;
        water_tank_level = 4'b0001;
        tick();
        tick();
        chk("reset", ALL_OFF);
        initialize = 1'b0;
        tick();
        chk("idle", ALL_OFF);

        // 1: sprinkler start sequence
        state = 2'b01;
        tick();
        chk("spr_open", OPEN_SPR);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("spr_open_hold", OPEN_SPR);
        end
        tick();
        chk("spr_pump_start", RUN_SPR);
        tick();
        chk("spr_run", RUN_SPR);

        // 2: direct switch sprinkler -> drip
        state = 2'b11;
        tick();
        chk("sw_stop", OPEN_SPR);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sw_stop_hold", OPEN_SPR);
        end
        tick();
        chk("sw_gap", ALL_OFF);
        tick();
        chk("drip_open", OPEN_DRIP);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("drip_open_hold", OPEN_DRIP);
        end
        tick();
        chk("drip_pump_start", RUN_DRIP);

        // 3: dry run while dripping, sticky fault
        water_tank_level = 4'b0000;
        tick();
        chk("dry_run_fault", FAULTED);
        state            = 2'b01;
        water_tank_level = 4'b0001;
        tick();
        chk("fault_sticky_a", FAULTED);
        state = 2'b00;
        tick();
        chk("fault_sticky_b", FAULTED);
        do_reset();
        chk("fault_cleared", ALL_OFF);
        tick();
        chk("fault_cleared_idle", ALL_OFF);

        // 4a: fill watchdog with a frozen level
        water_tank_level = 4'b0011;
        state            = 2'b10;
        tick();
        chk("fill_open", OPEN_FILL);
        for (int i = 0; i < 3; i++) tick();
        tick();
        chk("fill_pump_start", RUN_FILL);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("fill_run", RUN_FILL);
        end
        tick();
        chk("fill_timeout", FAULTED);
        do_reset();
        chk("reset_after_timeout", ALL_OFF);

        // 4b: level rises at cycle 5, watchdog restarts
        state = 2'b10;
        tick();
        chk("fill2_open", OPEN_FILL);
        for (int i = 0; i < 3; i++) tick();
        tick();
        chk("fill2_pump_start", RUN_FILL);
        for (int i = 0; i < 4; i++) tick();
        water_tank_level = 4'b0111;
        tick();
        chk("fill2_level_change", RUN_FILL);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("fill2_no_fault", RUN_FILL);
        end
        // Level moves on the very edge the watchdog would expire
        water_tank_level = 4'b1111;
        tick();
        chk("fill2_change_on_timeout", RUN_FILL);
        for (int i = 0; i < 7; i++) tick();
        chk("fill2_before_timeout", RUN_FILL);
        tick();
        chk("fill2_timeout", FAULTED);
        water_tank_level = 4'b0001;
        do_reset();
        chk("reset_after_fill2", ALL_OFF);

        // 5: request withdrawn during S_OPEN
        state = 2'b01;
        tick();
        chk("abort_open", OPEN_SPR);
        tick();
        chk("abort_open2", OPEN_SPR);
        state = 2'b00;
        tick();
        chk("abort_stop", OPEN_SPR);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_stop_hold", OPEN_SPR);
        end
        tick();
        chk("abort_closed", ALL_OFF);

        // 6: initialize mid-run, then full restart
        state = 2'b01;
        tick();
        for (int i = 0; i < 3; i++) tick();
        tick();
        chk("mid_run", RUN_SPR);
        initialize = 1'b1;
        tick();
        chk("mid_run_reset", ALL_OFF);
        initialize = 1'b0;
        tick();
        chk("restart_open", OPEN_SPR);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("restart_open_hold", OPEN_SPR);
        end
        tick();
        chk("restart_run", RUN_SPR);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/irrigation_actuator.md
Name: irrigation_actuator

Overview:
- Receives the 2-bit irrigation controller state code and drives the physical actuators: pump, sprinkler valve, drip valve and tank-fill valve.
- Enforces safe sequencing: the valve opens before the pump starts, the pump stops before the valve closes, and there is never overlap between modes.
- Adds dry-run and fill-watchdog protection with a sticky fault flag.
- Sits between the controller state register and the plant I/O.

Parameters:
- VALVE_DLY, 4: cycles the valve is open before the pump starts (>=1).
- PUMP_STOP_DLY, 4: cycles the pump is off before the valve closes (>=1).
- FILL_TIMEOUT, 1000: cycles in fill mode with no tank-level change before a fault is raised (>=2).
- CNT_W, 16: sequencing counter width; all delays must be < 2^CNT_W.

Ports:
- clk, input, 1, system clock.
- initialize, input, 1, reset (see interface rule below).
- state, input, 2, controller mode code: 00 IDLE, 01 SPRINKLER, 10 FILLING, 11 DRIP.
- water_tank_level, input, 4, thermometer code; bit0 = tank minimum, bit3 = tank full.
- pump_on, output, 1, pump enable.
- valve_sprinkler, output, 1, sprinkler valve open.
- valve_drip, output, 1, drip valve open.
- valve_fill, output, 1, tank-fill valve open.
- active, output, 1, sequencer is not in S_OFF.
- fault, output, 1, sticky fault indicator.

Interface rule: one clock; reset is synchronous and active-high (clk, initialize).

Behaviour:
- Reset: at a clk edge with initialize=1, FSM goes to S_OFF, target=00, cnt=0, snapshot=0. All outputs are 0. The same applies mid-operation and clears fault.
- Output decode: all outputs are decoded only from registered FSM state and target. There is no combinational path from inputs to outputs.
- Valve select: in S_OPEN, S_RUN and S_STOP, exactly one valve is high, chosen by target (01 sprinkler, 11 drip, 10 fill).
- S_OFF: all outputs 0.
  - If state != 00: target <= state, cnt <= 0, go to S_OPEN. The valve rises one cycle after the edge that samples the request.
- S_OPEN: valve=1, pump=0; cnt increments each cycle.
  - If state != target: cnt <= 0, go to S_STOP.
  - Else if cnt == VALVE_DLY-1: cnt <= 0, snapshot <= water_tank_level, go to S_RUN.
  - Result: the pump rises exactly VALVE_DLY cycles after the valve.
- S_RUN: valve=1, pump=1. Priority order, highest first:
  1. Dry run: target is 01 or 11 and water_tank_level[0]==0 -> S_FAULT.
  2. Fill timeout: target==10, water_tank_level==snapshot and cnt==FILL_TIMEOUT-1 -> S_FAULT.
  3. Mode change: state != target -> cnt <= 0, go to S_STOP.
  4. Otherwise, when target==10: if the level changed, snapshot <= level and cnt <= 0; else cnt++. For target 01/11, cnt holds.
- S_STOP: pump=0, valve=1; cnt increments.
  - When cnt == PUMP_STOP_DLY-1, go to S_OFF; the valve closes.
  - Input state changes are ignored here; no pre-emption.
- Mode switch: a direct switch (e.g. 01->11) always goes RUN -> STOP -> OFF (one all-zero cycle) -> OPEN with the new target. Two valves are never open simultaneously.
- S_FAULT: all actuators 0, fault=1, active=1. Exit only via initialize.
- Boundaries:
  - A request that returns to 00 during S_OPEN aborts via S_STOP, without the pump ever starting.
  - A level change on the same cycle as the timeout edge clears the watchdog (no fault).
  - The counter saturates, never wraps.

Decomposition:
- Shared package/header irrigation_pkg:
  - mode codes MODE_IDLE=2'b00, MODE_SPRINKLER=2'b01, MODE_FILLING=2'b10, MODE_DRIP=2'b11, also used by the controller;
  - sequencer encodings S_OFF, S_OPEN, S_RUN, S_STOP, S_FAULT.
- One natural sub-module: seq_counter (CNT_W, with clear, enable, saturation and a terminal-compare input). It is instantiated once and shared across states.

Test Plan:
1. Reset, then state=01, level=0001, VALVE_DLY=4 -> valve_sprinkler high 1 cycle after sampling; pump_on high exactly 4 cycles later; valve_fill and valve_drip stay 0.
2. Running sprinkler, state->11 -> pump_on drops next cycle; sprinkler valve held 4 cycles; one all-zero cycle; valve_drip rises; pump_on rises 4 cycles later.
3. Running drip, level->0000 -> next cycle all actuators 0, fault=1. Further state changes have no effect until initialize=1 for one edge, which clears everything to 0.
4. state=10, FILL_TIMEOUT=8, level held at 0011 -> fault rises exactly 8 cycles after pump start. Repeat with level->0111 at cycle 5 -> no fault; watchdog restarts.
5. state=01 then 00 after 2 cycles of S_OPEN -> pump_on never asserts; valve closes after PUMP_STOP_DLY; active=0.
6. Assert initialize mid-S_RUN -> the next edge gives all outputs 0 and S_OFF; the following request restarts the full open sequence.
